// File: rtl/tetris_pkg.sv
// tetris_pkg
// Shared definitions for the 4x8 Tetris game sequencer: controller state
// encoding, piece type codes, board geometry, the spawn-area mask and small
// helper functions used by the controller.
// Optional feature macro used by the design: TETRIS_LINE_CLEAR_EN.
package tetris_pkg;

  localparam int BOARD_W    = 4;
  localparam int BOARD_H    = 8;
  localparam int BOARD_BITS = BOARD_W * BOARD_H;

  // Cells 1,2 of rows 0..2: the area a freshly spawned piece occupies.
  localparam logic [BOARD_BITS-1:0] SPAWN_MASK = 32'h0000_0666;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_SPAWN   = 4'd1,
    ST_WAIT    = 4'd2,
    ST_STEP    = 4'd3,
    ST_CAPTURE = 4'd4,
    ST_LOCK    = 4'd5,
    ST_CLEAR   = 4'd6,
    ST_OVER    = 4'd7
  } state_e;

  typedef enum logic [1:0] {
    PIECE_I1 = 2'b00,
    PIECE_I2 = 2'b01,
    PIECE_L3 = 2'b10,
    PIECE_S3 = 2'b11
  } piece_e;

  // True when the spawn area is already occupied, i.e. the game is lost.
  function automatic logic spawn_blocked(input logic [BOARD_BITS-1:0] brd);
    return |(brd & SPAWN_MASK);
  endfunction

  // Pending move bits are {rotate, right, left}; left wins over right,
  // right wins over rotate. Result is one-hot or zero.
  function automatic logic [2:0] move_select(input logic [2:0] pend);
    logic [2:0] sel;
    if (pend[0]) begin
      sel = 3'b001;
    end else if (pend[1]) begin
      sel = 3'b010;
    end else if (pend[2]) begin
      sel = 3'b100;
    end else begin
      sel = 3'b000;
    end
    return sel;
  endfunction

endpackage

// File: rtl/tetris_game_ctrl_if.sv
// tetris_game_ctrl_if
// Request/response bus between the game sequencer and the move_piece
// datapath.
//   master (sequencer): drives mv_step, mv_board, mv_type, mv_location,
//                       mv_rotation, mv_left, mv_right, mv_rotate;
//                       receives mv_new_board, mv_new_location,
//                       mv_new_rotation, mv_touched.
//   slave  (datapath):  the mirror image.
interface tetris_game_ctrl_if;
  import tetris_pkg::*;

  logic                  mv_step;
  logic [BOARD_BITS-1:0] mv_board;
  logic [1:0]            mv_type;
  logic [4:0]            mv_location;
  logic [1:0]            mv_rotation;
  logic                  mv_left;
  logic                  mv_right;
  logic                  mv_rotate;
  logic [BOARD_BITS-1:0] mv_new_board;
  logic [4:0]            mv_new_location;
  logic [1:0]            mv_new_rotation;
  logic                  mv_touched;

  modport master (
    output mv_step, mv_board, mv_type, mv_location, mv_rotation,
           mv_left, mv_right, mv_rotate,
    input  mv_new_board, mv_new_location, mv_new_rotation, mv_touched
  );

  modport slave (
    input  mv_step, mv_board, mv_type, mv_location, mv_rotation,
           mv_left, mv_right, mv_rotate,
    output mv_new_board, mv_new_location, mv_new_rotation, mv_touched
  );

endinterface

// File: rtl/tetris_row_clear.sv
// tetris_row_clear
// Combinational single-row helper for line clearing.
//   board_i    in  32  committed board (bit 4r+c = row r, col c; row 0 top)
//   row_i      in  3   row under evaluation
//   full_o     out 1   every cell of row_i is set
//   shifted_o  out 32  board with row_i removed: rows 0..row_i-1 move down
//                      one row, row 0 becomes empty, lower rows unchanged
// Only instantiated when TETRIS_LINE_CLEAR_EN is defined.
module tetris_row_clear
  import tetris_pkg::*;
(
  input  logic [BOARD_BITS-1:0] board_i,
  input  logic [2:0]            row_i,
  output logic                  full_o,
  output logic [BOARD_BITS-1:0] shifted_o
);

  // Full-row detect and shift-down of everything above the row.
  always_comb begin
    full_o          = &board_i[{row_i, 2'b00} +: BOARD_W];
    shifted_o       = board_i;
    shifted_o[BOARD_W-1:0] = {BOARD_W{1'b0}};
    for (int i = 1; i < BOARD_H; i++) begin
      if (i <= int'(row_i)) begin
        shifted_o[i*BOARD_W +: BOARD_W] = board_i[(i-1)*BOARD_W +: BOARD_W];
      end else begin
        shifted_o[i*BOARD_W +: BOARD_W] = board_i[i*BOARD_W +: BOARD_W];
      end
    end
  end

endmodule

// File: rtl/tetris_game_ctrl.sv
// tetris_game_ctrl
// Top-level game sequencer for the 4x8 board. Owns the committed board, the
// active piece (type/location/rotation) and the drop timer; issues one step
// request per drop tick to the move_piece datapath and commits its results,
// then locks, optionally clears full rows, spawns and detects game over.
// Ports:
//   clka, rst_n            clock (rising edge), synchronous active-low reset
//   start                  level; starts a game from IDLE or OVER
//   left, right, rotate    synchronised button levels (edge detected here)
//   mv                     datapath bus (tetris_game_ctrl_if.master)
//   board                  committed board for the display
//   game_over, busy        status
//   lines                  cleared-row count (0 unless feature enabled)
// Parameters: DROP_TICKS (>=2), MV_LAT (>=1), SPAWN_LOC.
// Macro TETRIS_LINE_CLEAR_EN adds the CLEAR state, row shifting and lines.
module tetris_game_ctrl
  import tetris_pkg::*;
#(
  parameter int DROP_TICKS = 1000,
  parameter int MV_LAT     = 2,
  parameter int SPAWN_LOC  = 5
) (
  input  logic                  clka,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  left,
  input  logic                  right,
  input  logic                  rotate,
  tetris_game_ctrl_if.master    mv,
  output logic [BOARD_BITS-1:0] board,
  output logic                  game_over,
  output logic                  busy,
  output logic [7:0]            lines
);

  localparam int TMR_W = $clog2(DROP_TICKS);
  localparam int LAT_W = $clog2(MV_LAT + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD     = TMR_W'(DROP_TICKS - 1);
  localparam logic [LAT_W-1:0] LAT_LOAD     = LAT_W'(MV_LAT);
  localparam logic [4:0]       SPAWN_ANCHOR = 5'(SPAWN_LOC);

  state_e                state_q, state_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic [LAT_W-1:0]      lat_q, lat_d;
  logic [2:0]            btn_q, btn_d;       // {rotate, right, left}
  logic [2:0]            pend_q, pend_d;
  logic [2:0]            move_q, move_d;
  logic [1:0]            type_cnt_q, type_cnt_d;
  piece_e                type_q, type_d;
  logic [4:0]            loc_q, loc_d;
  logic [1:0]            rot_q, rot_d;
  logic [BOARD_BITS-1:0] board_q, board_d;
  logic                  step_q, step_d;
  logic                  over_q, over_d;
  logic                  busy_q, busy_d;
  logic [2:0]            rise;

`ifdef TETRIS_LINE_CLEAR_EN
  logic [2:0]            row_q, row_d;
  logic [7:0]            lines_q, lines_d;
  logic                  row_full;
  logic [BOARD_BITS-1:0] row_shifted;

  tetris_row_clear u_row_clear (
    .board_i   (board_q),
    .row_i     (row_q),
    .full_o    (row_full),
    .shifted_o (row_shifted)
  );
`endif

  // Next-state, datapath request and board/piece update logic.
  always_comb begin
    btn_d      = {rotate, right, left};
    rise       = btn_d & ~btn_q;
    state_d    = state_q;
    timer_d    = timer_q;
    lat_d      = lat_q;
    pend_d     = pend_q | rise;
    move_d     = move_q;
    type_cnt_d = type_cnt_q;
    type_d     = type_q;
    loc_d      = loc_q;
    rot_d      = rot_q;
    board_d    = board_q;
    step_d     = 1'b0;
`ifdef TETRIS_LINE_CLEAR_EN
    row_d      = row_q;
    lines_d    = lines_q;
`endif

    case (state_q)
      ST_IDLE, ST_OVER: begin
        // A new game always starts from an empty board.
        if (start) begin
          state_d = ST_SPAWN;
          board_d = {BOARD_BITS{1'b0}};
`ifdef TETRIS_LINE_CLEAR_EN
          lines_d = 8'h00;
`endif
        end else begin
          state_d = state_q;
        end
      end
      ST_SPAWN: begin
        type_d     = piece_e'(type_cnt_q);
        type_cnt_d = type_cnt_q + 2'd1;
        loc_d      = SPAWN_ANCHOR;
        rot_d      = 2'b00;
        if (spawn_blocked(board_q)) begin
          state_d = ST_OVER;
        end else begin
          state_d = ST_WAIT;
          timer_d = TMR_LOAD;
        end
      end
      ST_WAIT: begin
        // The move is latched from pending state; an edge seen in this
        // same cycle survives into the next drop.
        if (timer_q == {TMR_W{1'b0}}) begin
          state_d = ST_STEP;
          step_d  = 1'b1;
          move_d  = move_select(pend_q);
          pend_d  = rise;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      ST_STEP: begin
        state_d = ST_CAPTURE;
        lat_d   = LAT_LOAD;
      end
      ST_CAPTURE: begin
        // Stays MV_LAT+1 cycles so the sample lands after the datapath's
        // MV_LAT-cycle latency has fully elapsed.
        if (lat_q == {LAT_W{1'b0}}) begin
          board_d = mv.mv_new_board;
          loc_d   = mv.mv_new_location;
          rot_d   = mv.mv_new_rotation;
          move_d  = 3'b000;
          if (mv.mv_touched) begin
            state_d = ST_LOCK;
          end else begin
            state_d = ST_WAIT;
            timer_d = TMR_LOAD;
          end
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      ST_LOCK: begin
`ifdef TETRIS_LINE_CLEAR_EN
        state_d = ST_CLEAR;
        row_d   = 3'd7;
`else
        state_d = ST_SPAWN;
`endif
      end
      ST_CLEAR: begin
`ifdef TETRIS_LINE_CLEAR_EN
        // A cleared row pulls the row above into its place, so the same
        // row index is re-evaluated before moving up.
        if (row_full) begin
          board_d = row_shifted;
          lines_d = (lines_q == 8'hFF) ? lines_q : lines_q + 8'd1;
        end else if (row_q == 3'd0) begin
          state_d = ST_SPAWN;
        end else begin
          row_d = row_q - 3'd1;
        end
`else
        state_d = ST_SPAWN;
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE) && (state_d != ST_OVER);
    over_d = (state_d == ST_OVER);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clka) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      timer_q    <= {TMR_W{1'b0}};
      lat_q      <= {LAT_W{1'b0}};
      btn_q      <= 3'b000;
      pend_q     <= 3'b000;
      move_q     <= 3'b000;
      type_cnt_q <= 2'b00;
      type_q     <= PIECE_I1;
      loc_q      <= 5'd0;
      rot_q      <= 2'b00;
      board_q    <= {BOARD_BITS{1'b0}};
      step_q     <= 1'b0;
      over_q     <= 1'b0;
      busy_q     <= 1'b0;
`ifdef TETRIS_LINE_CLEAR_EN
      row_q      <= 3'd0;
      lines_q    <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      lat_q      <= lat_d;
      btn_q      <= btn_d;
      pend_q     <= pend_d;
      move_q     <= move_d;
      type_cnt_q <= type_cnt_d;
      type_q     <= type_d;
      loc_q      <= loc_d;
      rot_q      <= rot_d;
      board_q    <= board_d;
      step_q     <= step_d;
      over_q     <= over_d;
      busy_q     <= busy_d;
`ifdef TETRIS_LINE_CLEAR_EN
      row_q      <= row_d;
      lines_q    <= lines_d;
`endif
    end
  end

  assign mv.mv_step     = step_q;
  assign mv.mv_board    = board_q;
  assign mv.mv_type     = type_q;
  assign mv.mv_location = loc_q;
  assign mv.mv_rotation = rot_q;
  assign mv.mv_left     = move_q[0];
  assign mv.mv_right    = move_q[1];
  assign mv.mv_rotate   = move_q[2];

  assign board     = board_q;
  assign game_over = over_q;
  assign busy      = busy_q;
`ifdef TETRIS_LINE_CLEAR_EN
  assign lines     = lines_q;
`else
  assign lines     = 8'h00;
`endif

endmodule

// File: tb/tb_tetris_game_ctrl.sv
// tb_tetris_game_ctrl
// Self-checking bench for tetris_game_ctrl with a scripted datapath model.
// Expected step requests are queued when stimulus is applied and popped when
// mv_step pulses. Expectations follow TETRIS_LINE_CLEAR_EN when defined.
module tb_tetris_game_ctrl;

  localparam int D  = 6;
  localparam int L  = 2;
  localparam int SL = 5;

`ifdef TETRIS_LINE_CLEAR_EN
  localparam logic [31:0] LOCK_BOARD = 32'h0000_0000;
  localparam logic [7:0]  LOCK_LINES = 8'd1;
`else
  localparam logic [31:0] LOCK_BOARD = 32'hF000_0000;
  localparam logic [7:0]  LOCK_LINES = 8'd0;
`endif

  typedef struct packed {
    logic [2:0]  mv;    // {rotate, right, left}
    logic [1:0]  typ;
    logic [4:0]  loc;
    logic [1:0]  rot;
    logic [31:0] brd;
  } step_t;

  logic        clka   = 1'b0;
  logic        rst_n  = 1'b0;
  logic        start  = 1'b0;
  logic        left   = 1'b0;
  logic        right  = 1'b0;
  logic        rotate = 1'b0;
  logic [31:0] board;
  logic        game_over;
  logic        busy;
  logic [7:0]  lines;

  tetris_game_ctrl_if mv_if ();

  tetris_game_ctrl #(.DROP_TICKS(D), .MV_LAT(L), .SPAWN_LOC(SL)) dut (
    .clka      (clka),
    .rst_n     (rst_n),
    .start     (start),
    .left      (left),
    .right     (right),
    .rotate    (rotate),
    .mv        (mv_if),
    .board     (board),
    .game_over (game_over),
    .busy      (busy),
    .lines     (lines)
  );

  always #5 clka = ~clka;

  int cyc = 0;
  always @(posedge clka) cyc <= cyc + 1;

  int    checks  = 0;
  int    errors  = 0;
  int    prev_at = 0;
  step_t exp_q[$];

  task automatic tick(input int n);
    repeat (n) @(posedge clka);
    #1;
  endtask

  task automatic set_garbage();
    mv_if.mv_new_board    = 32'hA5A5_5A5A;
    mv_if.mv_new_location = 5'd31;
    mv_if.mv_new_rotation = 2'd3;
    mv_if.mv_touched      = 1'b1;
  endtask

  function automatic step_t observe();
    return {mv_if.mv_rotate, mv_if.mv_right, mv_if.mv_left, mv_if.mv_type,
            mv_if.mv_location, mv_if.mv_rotation, mv_if.mv_board};
  endfunction

  task automatic wait_step(output bit ok, output int at);
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (mv_if.mv_step === 1'b1) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
  endtask

  // Datapath model: results become valid L cycles after the step and are
  // garbage otherwise. Returns the board just before and just after commit.
  task automatic serve(input logic [31:0] nb, input logic [4:0] nl,
                       input logic [1:0] nr, input logic t,
                       output logic [31:0] pre, output logic [31:0] post);
    set_garbage();
    tick(L);
    mv_if.mv_new_board    = nb;
    mv_if.mv_new_location = nl;
    mv_if.mv_new_rotation = nr;
    mv_if.mv_touched      = t;
    tick(1);
    pre = board;
    tick(1);
    post = board;
    set_garbage();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    checks++;
    if ({board, lines} !== 40'h0) begin
      errors++; $display("FAIL reset_board got %h/%h want 0/0", board, lines);
    end
    checks++;
    if ({game_over, busy, mv_if.mv_step} !== 3'b000) begin
      errors++; $display("FAIL reset_status got %b want 000", {game_over, busy, mv_if.mv_step});
    end
    checks++;
    if (observe() !== '0) begin
      errors++; $display("FAIL reset_mv got %h want 0", observe());
    end
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_spawn();
    bit ok; int at, c0; step_t e, g; logic [31:0] pre, post;
    start = 1'b1;
    tick(1);
    c0 = cyc;
    start = 1'b0;
    checks++;
    if ({busy, game_over} !== 2'b10) begin
      errors++; $display("FAIL start_busy got %b want 10", {busy, game_over});
    end
    tick(1);
    checks++;
    if ({mv_if.mv_type, mv_if.mv_location, mv_if.mv_rotation} !== {2'b00, 5'd5, 2'b00}) begin
      errors++; $display("FAIL spawn_piece got %h/%0d/%0d want 0/5/0",
                         mv_if.mv_type, mv_if.mv_location, mv_if.mv_rotation);
    end
    exp_q.push_back({3'b000, 2'b00, 5'd5, 2'b00, 32'h0});
    wait_step(ok, at);
    checks++;
    if (!ok || (at - c0) != D + 1) begin
      errors++; $display("FAIL first_step_delay got %0d (seen %0d) want %0d", at - c0, ok, D + 1);
    end
    e = exp_q.pop_front();
    g = observe();
    checks++;
    if (g !== e) begin
      errors++; $display("FAIL first_step got %h want %h", g, e);
    end
    prev_at = at;
    serve(32'h0000_0100, 5'd9, 2'd0, 1'b0, pre, post);
    checks++;
    if ({pre, post} !== {32'h0, 32'h0000_0100}) begin
      errors++; $display("FAIL commit_latency got %h->%h want 0->00000100", pre, post);
    end
  endtask

  task automatic test_left();
    bit ok; int at; step_t e, g; logic [31:0] pre, post;
    tick(2);
    left = 1'b1;
    tick(1);
    left  = 1'b0;
    start = 1'b1;   // must be ignored while busy
    tick(1);
    start = 1'b0;
    exp_q.push_back({3'b001, 2'b00, 5'd9, 2'b00, 32'h0000_0100});
    wait_step(ok, at);
    checks++;
    if (!ok || (at - prev_at) != D + L + 2) begin
      errors++; $display("FAIL drop_period got %0d (seen %0d) want %0d", at - prev_at, ok, D + L + 2);
    end
    e = exp_q.pop_front();
    g = observe();
    checks++;
    if (g !== e) begin
      errors++; $display("FAIL left_step got %h want %h", g, e);
    end
    serve(32'h0000_1100, 5'd8, 2'd1, 1'b0, pre, post);
    checks++;
    if (post !== 32'h0000_1100) begin
      errors++; $display("FAIL left_commit got %h want 00001100", post);
    end
  endtask

  task automatic test_no_press();
    bit ok; int at; step_t e, g; logic [31:0] pre, post;
    exp_q.push_back({3'b000, 2'b00, 5'd8, 2'b01, 32'h0000_1100});
    wait_step(ok, at);
    e = exp_q.pop_front();
    g = observe();
    checks++;
    if (!ok || g !== e) begin
      errors++; $display("FAIL idle_step got %h (seen %0d) want %h", g, ok, e);
    end
    serve(32'h0001_1000, 5'd12, 2'd1, 1'b0, pre, post);
    checks++;
    if ({pre, post} !== {32'h0000_1100, 32'h0001_1000}) begin
      errors++; $display("FAIL idle_commit got %h->%h want 00001100->00011000", pre, post);
    end
  endtask

  task automatic test_right_rotate();
    bit ok; int at; step_t e, g; logic [31:0] pre, post;
    tick(1);
    right  = 1'b1;
    rotate = 1'b1;
    tick(1);
    right  = 1'b0;
    rotate = 1'b0;
    exp_q.push_back({3'b010, 2'b00, 5'd12, 2'b01, 32'h0001_1000});
    wait_step(ok, at);
    e = exp_q.pop_front();
    g = observe();
    checks++;
    if (!ok || g !== e) begin
      errors++; $display("FAIL right_rotate_step got %h (seen %0d) want %h", g, ok, e);
    end
    serve(32'h0011_0000, 5'd16, 2'd1, 1'b0, pre, post);
  endtask

  task automatic test_left_rotate_lock();
    bit ok; int at; step_t e, g; logic [31:0] pre, post;
    tick(1);
    left   = 1'b1;
    rotate = 1'b1;
    tick(1);
    left   = 1'b0;
    rotate = 1'b0;
    exp_q.push_back({3'b001, 2'b00, 5'd16, 2'b01, 32'h0011_0000});
    wait_step(ok, at);
    e = exp_q.pop_front();
    g = observe();
    checks++;
    if (!ok || g !== e) begin
      errors++; $display("FAIL left_rotate_step got %h (seen %0d) want %h", g, ok, e);
    end
    serve(32'h0110_0000, 5'd20, 2'd1, 1'b0, pre, post);
    exp_q.push_back({3'b000, 2'b00, 5'd20, 2'b01, 32'h0110_0000});
    wait_step(ok, at);
    e = exp_q.pop_front();
    g = observe();
    checks++;
    if (!ok || g !== e) begin
      errors++; $display("FAIL rotate_discarded got %h (seen %0d) want %h", g, ok, e);
    end
    serve(32'hF000_0000, 5'd20, 2'd1, 1'b1, pre, post);
    checks++;
    if (post !== 32'hF000_0000) begin
      errors++; $display("FAIL touch_commit got %h want f0000000", post);
    end
    exp_q.push_back({3'b000, 2'b01, 5'd5, 2'b00, LOCK_BOARD});
    wait_step(ok, at);
    e = exp_q.pop_front();
    g = observe();
    checks++;
    if (!ok || g !== e) begin
      errors++; $display("FAIL after_lock_step got %h (seen %0d) want %h", g, ok, e);
    end
    checks++;
    if ({lines, busy} !== {LOCK_LINES, 1'b1}) begin
      errors++; $display("FAIL lines_count got %0d/%b want %0d/1", lines, busy, LOCK_LINES);
    end
  endtask

  task automatic test_game_over();
    bit ok; int at; step_t e, g; logic [31:0] pre, post;
    serve(32'h0000_0020, 5'd5, 2'd0, 1'b1, pre, post);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (game_over === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    checks++;
    if (!ok) begin
      errors++; $display("FAIL over_timeout got game_over=%b want 1 within 40 cycles", game_over);
    end
    tick(3);
    checks++;
    if ({game_over, busy, board, mv_if.mv_type} !== {1'b1, 1'b0, 32'h0000_0020, 2'b10}) begin
      errors++; $display("FAIL over_state got %b/%b/%h/%h want 1/0/00000020/2",
                         game_over, busy, board, mv_if.mv_type);
    end
    start = 1'b1;
    tick(1);
    start = 1'b0;
    checks++;
    if ({game_over, busy, board} !== {1'b0, 1'b1, 32'h0}) begin
      errors++; $display("FAIL restart got %b/%b/%h want 0/1/0", game_over, busy, board);
    end
    exp_q.push_back({3'b000, 2'b11, 5'd5, 2'b00, 32'h0});
    wait_step(ok, at);
    e = exp_q.pop_front();
    g = observe();
    checks++;
    if (!ok || g !== e) begin
      errors++; $display("FAIL restart_step got %h (seen %0d) want %h", g, ok, e);
    end
  endtask

  task automatic test_reset_in_capture();
    set_garbage();
    tick(1);
    mv_if.mv_new_board    = 32'h1234_5678;
    mv_if.mv_new_location = 5'd9;
    mv_if.mv_new_rotation = 2'd1;
    mv_if.mv_touched      = 1'b0;
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    checks++;
    if ({board, busy, game_over, mv_if.mv_step, mv_if.mv_type} !== 37'h0) begin
      errors++; $display("FAIL abort_reset got %h/%b/%b/%b/%h want all 0",
                         board, busy, game_over, mv_if.mv_step, mv_if.mv_type);
    end
    tick(L + 3);
    checks++;
    if ({board, busy, mv_if.mv_location} !== 38'h0) begin
      errors++; $display("FAIL late_result got %h/%b/%0d want 0/0/0", board, busy, mv_if.mv_location);
    end
    set_garbage();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish before 200us");
    $fatal(1);
  end

  initial begin
    set_garbage();
    test_reset();
    test_spawn();
    test_left();
    test_no_press();
    test_right_rotate();
    test_left_rotate_lock();
    test_game_over();
    test_reset_in_capture();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
